cpu_control: RTL and testbench

- Microcode sequencer for the 8-bit accumulator CPU.
- Each instruction runs as 2 fetch T-states plus up to 3 execute T-states. The block drives one control word per T-state to the bus drivers, registers, ALU and program counter.
- Inputs are the instruction-register opcode nibble and the flags register (C, Z).
- Sits inside cpu between the instruction register and all datapath enables; replaces hand-wired control.

---
 rtl/cpu_control.sv | 154 +++++++++++++++
 tb/tb_cpu_control.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_control.sv
// ============================================================================
// Module      : cpu_control
// Description : Microcode step sequencer for the 8-bit accumulator CPU.
//               Emits one 16-bit datapath control word per T-state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_control #(
    parameter int EARLY_END  = 1,
    parameter int HALT_LATCH = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [3:0]  i_opcode,
    input  logic        i_flag_c,
    input  logic        i_flag_z,
    output logic [15:0] o_ctrl,
    output logic [2:0]  o_step,
    output logic        o_halted
);

    localparam logic [15:0] c_hlt = 16'h8000;
    localparam logic [15:0] c_mi  = 16'h4000;
    localparam logic [15:0] c_ri  = 16'h2000;
    localparam logic [15:0] c_ro  = 16'h1000;
    localparam logic [15:0] c_io  = 16'h0800;
    localparam logic [15:0] c_ii  = 16'h0400;
    localparam logic [15:0] c_ai  = 16'h0200;
    localparam logic [15:0] c_ao  = 16'h0100;
    localparam logic [15:0] c_eo  = 16'h0080;
    localparam logic [15:0] c_su  = 16'h0040;
    localparam logic [15:0] c_bi  = 16'h0020;
    localparam logic [15:0] c_oi  = 16'h0010;
    localparam logic [15:0] c_ce  = 16'h0008;
    localparam logic [15:0] c_co  = 16'h0004;
    localparam logic [15:0] c_j   = 16'h0002;
    localparam logic [15:0] c_fi  = 16'h0001;

    localparam logic [3:0] c_op_lda = 4'h1;
    localparam logic [3:0] c_op_add = 4'h2;
    localparam logic [3:0] c_op_sub = 4'h3;
    localparam logic [3:0] c_op_sta = 4'h4;
    localparam logic [3:0] c_op_ldi = 4'h5;
    localparam logic [3:0] c_op_jmp = 4'h6;
    localparam logic [3:0] c_op_jc  = 4'h7;
    localparam logic [3:0] c_op_jz  = 4'h8;
    localparam logic [3:0] c_op_out = 4'hE;
    localparam logic [3:0] c_op_hlt = 4'hF;

    // Microcode ROM; flags only influence step 2 because jumps resolve there.
    function automatic logic [15:0] f_word(input logic [2:0] step,
                                           input logic [3:0] op,
                                           input logic       fc,
                                           input logic       fz);
        logic [15:0] w;
        w = '0;
        case (step)
            3'd0: w = c_co | c_mi;
            3'd1: w = c_ro | c_ii | c_ce;
            3'd2: begin
                case (op)
                    c_op_lda, c_op_add,
                    c_op_sub, c_op_sta: w = c_io | c_mi;
                    c_op_ldi:           w = c_io | c_ai;
                    c_op_jmp:           w = c_io | c_j;
                    c_op_jc:            w = fc ? (c_io | c_j) : 16'h0000;
                    c_op_jz:            w = fz ? (c_io | c_j) : 16'h0000;
                    c_op_out:           w = c_ao | c_oi;
                    c_op_hlt:           w = c_hlt;
                    default:            w = '0;
                endcase
            end
            3'd3: begin
                case (op)
                    c_op_lda:           w = c_ro | c_ai;
                    c_op_add, c_op_sub: w = c_ro | c_bi;
                    c_op_sta:           w = c_ao | c_ri;
                    default:            w = '0;
                endcase
            end
            3'd4: begin
                case (op)
                    c_op_add: w = c_eo | c_ai | c_fi;
                    c_op_sub: w = c_eo | c_ai | c_su | c_fi;
                    default:  w = '0;
                endcase
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    logic [2:0]  r_step;
    logic        r_halted;
    logic [15:0] w_word;
    logic [15:0] w_word_next;
    logic [2:0]  w_step_inc;
    logic [2:0]  w_step_next;
    logic        w_end_early;
    logic        w_halt_now;

    assign w_step_inc  = r_step + 3'd1;
    assign w_word      = f_word(r_step, i_opcode, i_flag_c, i_flag_z);
    assign w_word_next = f_word(w_step_inc, i_opcode, 1'b0, 1'b0);

    generate
        if (EARLY_END != 0) begin : g_early_end
            assign w_end_early = (w_word_next == 16'h0000);
        end else begin : g_full_run
            assign w_end_early = 1'b0;
        end
    endgenerate

    generate
        if (HALT_LATCH != 0) begin : g_halt_latch
            assign w_halt_now = (r_step == 3'd2) && (i_opcode == c_op_hlt);
        end else begin : g_halt_pulse
            assign w_halt_now = 1'b0;
        end
    endgenerate

    always_comb begin
        w_step_next = 3'd0;
        case (r_step)
            3'd0:       w_step_next = 3'd1;
            3'd1:       w_step_next = 3'd2;
            3'd2, 3'd3: w_step_next = w_end_early ? 3'd0 : w_step_inc;
            default:    w_step_next = 3'd0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_step   <= 3'd0;
            r_halted <= 1'b0;
        end else if (i_en && !r_halted) begin
            if (w_halt_now) begin
                r_step   <= 3'd0;
                r_halted <= 1'b1;
            end else begin
                r_step   <= w_step_next;
            end
        end
    end

    assign o_ctrl   = (i_rst && i_en && !r_halted) ? w_word : 16'h0000;
    assign o_step   = r_step;
    assign o_halted = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_cpu_control.sv
// ============================================================================
// Module      : tb_cpu_control
// Description : Directed scoreboard bench for cpu_control (both build options).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        fc;
    logic        fz;
    logic [3:0]  op;
    logic [15:0] ctrl_a, ctrl_b;
    logic [2:0]  step_a, step_b;
    logic        halt_a, halt_b;

    always #5 clk = ~clk;

    cpu_control dut_a (
        .i_clk(clk), .i_rst(rst_n), .i_en(en), .i_opcode(op),
        .i_flag_c(fc), .i_flag_z(fz),
        .o_ctrl(ctrl_a), .o_step(step_a), .o_halted(halt_a)
    );

    cpu_control #(.EARLY_END(0), .HALT_LATCH(0)) dut_b (
        .i_clk(clk), .i_rst(rst_n), .i_en(en), .i_opcode(op),
        .i_flag_c(fc), .i_flag_z(fz),
        .o_ctrl(ctrl_b), .o_step(step_b), .o_halted(halt_b)
    );

    typedef struct packed {
        logic        sel;
        logic [15:0] ctrl;
        logic [2:0]  step;
        logic        halted;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic expect_on(input logic sel, input string tag,
                             input logic [15:0] ctrl, input logic [2:0] step,
                             input logic halted);
        exp_t e;
        e.sel = sel; e.ctrl = ctrl; e.step = step; e.halted = halted;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Compare all queued expectations mid-cycle, then advance past the next edge.
    task automatic cyc();
        exp_t        e;
        string       t;
        logic [15:0] oc;
        logic [2:0]  os;
        logic        oh;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            t  = tag_q.pop_front();
            oc = e.sel ? ctrl_b : ctrl_a;
            os = e.sel ? step_b : step_a;
            oh = e.sel ? halt_b : halt_a;
            checks++;
            assert (oc === e.ctrl) else begin
                failures++;
                $error("FAIL %s ctrl: observed %h expected %h", t, oc, e.ctrl);
            end
            checks++;
            assert (os === e.step) else begin
                failures++;
                $error("FAIL %s step: observed %0d expected %0d", t, os, e.step);
            end
            checks++;
            assert (oh === e.halted) else begin
                failures++;
                $error("FAIL %s halted: observed %b expected %b", t, oh, e.halted);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ws packs words for steps 0..4, step 0 in the low 16 bits.
    task automatic seq(input string tag, input int n, input logic [79:0] ws);
        for (int i = 0; i < n; i++) begin
            expect_on(1'b0, tag, ws[i*16 +: 16], 3'(i), 1'b0);
            cyc();
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; op = 4'h0; fc = 1'b0; fz = 1'b0;
        @(posedge clk);
        #1;
        expect_on(1'b0, "reset_a", 16'h0000, 3'd0, 1'b0);
        expect_on(1'b1, "reset_b", 16'h0000, 3'd0, 1'b0);
        cyc();
        rst_n = 1'b1;

        op = 4'h1; seq("lda", 4, {16'h0000, 16'h1200, 16'h4800, 16'h1408, 16'h4004});
        op = 4'h2; seq("add", 5, {16'h0281, 16'h1020, 16'h4800, 16'h1408, 16'h4004});
        op = 4'h3; seq("sub", 5, {16'h02C1, 16'h1020, 16'h4800, 16'h1408, 16'h4004});

        op = 4'h7; fc = 1'b0;
        seq("jc_nt", 3, {16'h0000, 16'h0000, 16'h0000, 16'h1408, 16'h4004});
        fc = 1'b1;
        seq("jc_t", 3, {16'h0000, 16'h0000, 16'h0802, 16'h1408, 16'h4004});
        op = 4'h8; fz = 1'b0;
        seq("jz_nt", 3, {16'h0000, 16'h0000, 16'h0000, 16'h1408, 16'h4004});
        fz = 1'b1; fc = 1'b0;
        seq("jz_t", 3, {16'h0000, 16'h0000, 16'h0802, 16'h1408, 16'h4004});

        // Carry only matters while step 2 is on the bus.
        op = 4'h7; fc = 1'b0;
        seq("jc_late", 2, {16'h0000, 16'h0000, 16'h0000, 16'h1408, 16'h4004});
        fc = 1'b1;
        expect_on(1'b0, "jc_late", 16'h0802, 3'd2, 1'b0);
        cyc();
        seq("jc_early", 2, {16'h0000, 16'h0000, 16'h0000, 16'h1408, 16'h4004});
        fc = 1'b0;
        expect_on(1'b0, "jc_early", 16'h0000, 3'd2, 1'b0);
        cyc();

        op = 4'h5; seq("ldi", 3, {16'h0000, 16'h0000, 16'h0A00, 16'h1408, 16'h4004});
        op = 4'h4; seq("sta", 4, {16'h0000, 16'h2100, 16'h4800, 16'h1408, 16'h4004});
        op = 4'hE; seq("out", 3, {16'h0000, 16'h0000, 16'h0110, 16'h1408, 16'h4004});
        op = 4'h6; seq("jmp", 3, {16'h0000, 16'h0000, 16'h0802, 16'h1408, 16'h4004});
        op = 4'hA; seq("nop_a", 3, {16'h0000, 16'h0000, 16'h0000, 16'h1408, 16'h4004});

        op = 4'h2; seq("add_en", 3, {16'h0000, 16'h0000, 16'h4800, 16'h1408, 16'h4004});
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_on(1'b0, "en_hold", 16'h0000, 3'd3, 1'b0);
            cyc();
        end
        en = 1'b1;
        expect_on(1'b0, "en_resume3", 16'h1020, 3'd3, 1'b0);
        cyc();
        expect_on(1'b0, "en_resume4", 16'h0281, 3'd4, 1'b0);
        cyc();

        seq("add_rst", 3, {16'h0000, 16'h0000, 16'h4800, 16'h1408, 16'h4004});
        rst_n = 1'b0; en = 1'b0;
        expect_on(1'b0, "rst_mid", 16'h0000, 3'd3, 1'b0);
        cyc();
        rst_n = 1'b1; en = 1'b1; op = 4'hF;
        expect_on(1'b0, "rst_after", 16'h4004, 3'd0, 1'b0);
        expect_on(1'b1, "rst_after_b", 16'h4004, 3'd0, 1'b0);
        cyc();

        expect_on(1'b0, "hlt_s1", 16'h1408, 3'd1, 1'b0);
        expect_on(1'b1, "hlt_s1_b", 16'h1408, 3'd1, 1'b0);
        cyc();
        expect_on(1'b0, "hlt_s2", 16'h8000, 3'd2, 1'b0);
        expect_on(1'b1, "hlt_s2_b", 16'h8000, 3'd2, 1'b0);
        cyc();
        for (int i = 0; i < 20; i++) begin
            expect_on(1'b0, "halted", 16'h0000, 3'd0, 1'b1);
            if (i == 0) expect_on(1'b1, "hlt_pulse_s3", 16'h0000, 3'd3, 1'b0);
            if (i == 1) expect_on(1'b1, "hlt_pulse_s4", 16'h0000, 3'd4, 1'b0);
            if (i == 2) expect_on(1'b1, "hlt_pulse_s0", 16'h4004, 3'd0, 1'b0);
            cyc();
        end
        rst_n = 1'b0;
        expect_on(1'b0, "halt_rst", 16'h0000, 3'd0, 1'b1);
        cyc();
        rst_n = 1'b1; op = 4'h0;
        expect_on(1'b0, "unhalt", 16'h4004, 3'd0, 1'b0);
        expect_on(1'b1, "nop_b_s0", 16'h4004, 3'd0, 1'b0);
        cyc();
        expect_on(1'b0, "nop_a_s1", 16'h1408, 3'd1, 1'b0);
        expect_on(1'b1, "nop_b_s1", 16'h1408, 3'd1, 1'b0);
        cyc();
        expect_on(1'b0, "nop_a_s2", 16'h0000, 3'd2, 1'b0);
        expect_on(1'b1, "nop_b_s2", 16'h0000, 3'd2, 1'b0);
        cyc();
        expect_on(1'b0, "nop_a_wrap", 16'h4004, 3'd0, 1'b0);
        expect_on(1'b1, "nop_b_s3", 16'h0000, 3'd3, 1'b0);
        cyc();
        expect_on(1'b1, "nop_b_s4", 16'h0000, 3'd4, 1'b0);
        cyc();
        expect_on(1'b1, "nop_b_wrap", 16'h4004, 3'd0, 1'b0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
